fpmult_execute_module: RTL and testbench

- Execute stage of the single-precision FP multiplier, directly downstream of the prep stage.
- Consumes the unpacked operands: signs, biased exponents, 24-bit mantissas with the explicit 1, and the 5-bit input-exception vector.
- Produces the product sign, the unbiased-sum exponent, the full 48-bit mantissa product and the zero/exception flags for the normalize/round stage.
- Three-stage pipeline with a valid/ready handshake. The mantissa multiply is split into two DSP48E1-sized partial products: 24x17 and 24x7.

---
 rtl/fpmult_execute_module.sv | 104 ++++++++++
 tb/tb_fpmult_execute_module.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_execute_module.sv
// FP multiplier execute stage: sign, exponent sum and split 24x24 mantissa
// product over a three-register pipeline with a valid/ready handshake.
module fpmult_execute_module #(
  parameter int BIAS = 127,
  parameter int LO_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sa,
  input  logic        Sb,
  input  logic [7:0]  Ea,
  input  logic [7:0]  Eb,
  input  logic [23:0] Ma,
  input  logic [23:0] Mb,
  input  logic [4:0]  InputExc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Sp,
  output logic [9:0]  Ep,
  output logic [47:0] Mp,
  output logic        Zero,
  output logic [4:0]  ExcOut
);

  localparam int HI_W = 24 - LO_W;

  typedef struct packed {
    logic       s;
    logic [9:0] e;
    logic       z;
    logic [4:0] exc;
  } ctl_t;

  logic en;
  ctl_t ctl0, ctl1, ctl2, ctl3;
  logic v1, v2;
  logic [23:0] ma1, mb1;
  logic [24+LO_W-1:0] pl2;
  logic [24+HI_W-1:0] ph2;
  logic [47:0] mpSum;
  logic [47:0] mp3;

  // One shared enable: the whole pipe moves only when the output slot frees.
  assign en = ~out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    ctl0.s   = Sa ^ Sb;
    ctl0.e   = {2'b00, Ea} + {2'b00, Eb} - 10'(BIAS);
    ctl0.z   = ~|Ea | ~|Eb;
    ctl0.exc = InputExc;
  end

  assign mpSum = 48'(pl2) + (48'(ph2) << LO_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      ctl1      <= '0;
      ma1       <= '0;
      mb1       <= '0;
    end else if (en) begin
      v1        <= in_valid;
      ctl1      <= ctl0;
      ma1       <= Ma;
      mb1       <= Mb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      ctl2 <= '0;
      pl2  <= '0;
      ph2  <= '0;
    end else if (en) begin
      v2   <= v1;
      ctl2 <= ctl1;
      pl2  <= ma1 * mb1[LO_W-1:0];
      ph2  <= ma1 * mb1[23:LO_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctl3      <= '0;
      mp3       <= '0;
    end else if (en) begin
      out_valid <= v2;
      ctl3      <= ctl2;
      mp3       <= mpSum;
    end
  end

  assign Sp     = ctl3.s;
  assign Ep     = ctl3.e;
  assign Zero   = ctl3.z;
  assign ExcOut = ctl3.exc;
  assign Mp     = mp3;

endmodule

// File: tb/tb_fpmult_execute_module.sv
// Directed bench for fpmult_execute_module: hand-computed vectors,
// scoreboard of vector indices, stall/bubble/reset scenarios.
module tb_fpmult_execute_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        Sa = 1'b0, Sb = 1'b0;
  logic [7:0]  Ea = '0, Eb = '0;
  logic [23:0] Ma = '0, Mb = '0;
  logic [4:0]  InputExc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        Sp;
  logic [9:0]  Ep;
  logic [47:0] Mp;
  logic        Zero;
  logic [4:0]  ExcOut;

  fpmult_execute_module dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sa(Sa), .Sb(Sb), .Ea(Ea), .Eb(Eb),
    .Ma(Ma), .Mb(Mb), .InputExc(InputExc),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sp(Sp), .Ep(Ep), .Mp(Mp), .Zero(Zero), .ExcOut(ExcOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [4:0]  exc;
    logic        xs;
    logic [9:0]  xe;
    logic [47:0] xm;
    logic        xz;
  } vec_t;

  vec_t vt[9];
  int sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input int i);
    Sa = vt[i].sa; Sb = vt[i].sb;
    Ea = vt[i].ea; Eb = vt[i].eb;
    Ma = vt[i].ma; Mb = vt[i].mb;
    InputExc = vt[i].exc;
  endtask

  // Present vector i and hold it until the pipe takes it.
  task automatic sendVec(input int i);
    int budget;
    @(posedge clk); #1;
    apply(i);
    in_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(i);
        break;
      end
      budget++;
      if (budget > 50) begin
        chk("acceptTimeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spuriousValid", 1, 0);
      end else if (out_ready) begin
        chk($sformatf("Sp[%0d]", sb[0]), Sp, vt[sb[0]].xs);
        chk($sformatf("Ep[%0d]", sb[0]), Ep, vt[sb[0]].xe);
        chk($sformatf("Mp[%0d]", sb[0]), Mp, vt[sb[0]].xm);
        chk($sformatf("Zero[%0d]", sb[0]), Zero, vt[sb[0]].xz);
        chk($sformatf("Exc[%0d]", sb[0]), ExcOut, vt[sb[0]].exc);
        void'(sb.pop_front());
      end else begin
        chk("stallInReady", in_ready, 0);
        chk($sformatf("holdMp[%0d]", sb[0]), Mp, vt[sb[0]].xm);
        chk($sformatf("holdEp[%0d]", sb[0]), Ep, vt[sb[0]].xe);
        chk($sformatf("holdExc[%0d]", sb[0]), ExcOut, vt[sb[0]].exc);
      end
    end
  end

  initial begin
    int lat;
    logic iv[11];
    logic ov[11];

    vt[0] = '{1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 5'b00000,
              1'b0, 10'h07F, 48'h400000000000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000, 5'b00000,
              1'b1, 10'h080, 48'h600000000000, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 5'b00000,
              1'b1, 10'h17D, 48'hFFFFFE000001, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'd1, 8'd1, 24'h800000, 24'h800000, 5'b00000,
              1'b0, 10'h383, 48'h400000000000, 1'b0};
    vt[4] = '{1'b0, 1'b0, 8'd0, 8'd130, 24'h400000, 24'h800000, 5'b00001,
              1'b0, 10'h003, 48'h200000000000, 1'b1};
    vt[5] = '{1'b0, 1'b0, 8'd255, 8'd127, 24'hC00000, 24'h800000, 5'b10100,
              1'b0, 10'h0FF, 48'h600000000000, 1'b0};
    vt[6] = '{1'b1, 1'b0, 8'd130, 8'd120, 24'hA00000, 24'h900000, 5'b00010,
              1'b1, 10'h07B, 48'h5A0000000000, 1'b0};
    vt[7] = '{1'b0, 1'b0, 8'd100, 8'd50, 24'h800001, 24'h800001, 5'b00000,
              1'b0, 10'h017, 48'h400001000001, 1'b0};
    vt[8] = '{1'b1, 1'b1, 8'd200, 8'd60, 24'hFFFFFF, 24'h810001, 5'b01000,
              1'b0, 10'h085, 48'h8100007EFFFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rstValid", out_valid, 0);
    chk("rstSp", Sp, 0);
    chk("rstEp", Ep, 0);
    chk("rstMp", Mp, 0);
    chk("rstZero", Zero, 0);
    chk("rstExc", ExcOut, 0);
    rst = 1'b0;
    #1;
    chk("rstInReady", in_ready, 1);

    // Single op with latency measurement
    sendVec(0);
    idle();
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 3);
    repeat (3) @(posedge clk);

    // Back-to-back directed vectors
    for (int i = 1; i < 9; i++) sendVec(i);
    idle();
    repeat (6) @(posedge clk);
    chk("drainDirected", sb.size(), 0);

    // Backpressure: 5 sets, stall 6 cycles starting at cycle 4
    fork
      begin
        sendVec(0); sendVec(1); sendVec(2); sendVec(5); sendVec(8);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    chk("drainStall", sb.size(), 0);

    // Bubbles: alternate in_valid for 8 cycles
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      apply(c % 9);
      in_valid = (c < 8) && (c % 2 == 0);
      iv[c] = in_valid;
      @(negedge clk);
      if (in_valid && in_ready) sb.push_back(c % 9);
      ov[c] = out_valid;
    end
    idle();
    for (int c = 0; c < 8; c++)
      chk($sformatf("bubble%0d", c), ov[c+3], iv[c]);
    repeat (4) @(posedge clk);
    chk("drainBubble", sb.size(), 0);

    // Reset mid-flight
    sendVec(2); sendVec(6); sendVec(7);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("preRstValid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("asyncRstValid", out_valid, 0);
    chk("asyncRstMp", Mp, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("postRst%0d", c), out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
